dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// word width, wait-state limit and a constant log2 helper.
package dmem_pkg;

    localparam int WORD_W          = 32;
    localparam int MAX_WAIT_CYCLES = 15;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions (returns 0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with write enable and enabled, registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
        if (rd_en) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack slave with WAIT_CYCLES wait states, range error
// checking and optional alignment checking (enabled by defining DMEM_ALIGN_CHECK_EN).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       adr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              ack,
    output logic              err
);

    localparam int AW = clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              we_reg;
    logic [31:0]       adr_reg;
    logic [31:0]       data_reg;
    logic              ack_reg, err_reg, zero_reg;

    logic              cur_we, cur_err, enter_resp, ram_wr, ram_rd;
    logic [31:0]       cur_adr, cur_data;
    logic [WORD_W-1:0] ram_q;

    // The access being serviced: live inputs on the accepting edge, captured copy afterwards.
    // This lets a zero-wait access hit the RAM on the same edge it is accepted.
    always_comb begin
        cur_we   = we_reg;
        cur_adr  = adr_reg;
        cur_data = data_reg;
        if (state_reg == IDLE) begin
            cur_we   = we;
            cur_adr  = adr;
            cur_data = data_in;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign cur_err = (|cur_adr[31:AW+2]) || (cur_adr[1:0] != 2'b00);
`else
    logic unused_adr_lsbs;
    assign unused_adr_lsbs = ^cur_adr[1:0];
    assign cur_err = |cur_adr[31:AW+2];
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LD;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state_reg != RESP);
    assign ram_wr     = enter_resp && cur_we && !cur_err;
    assign ram_rd     = enter_resp && !cur_we && !cur_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            adr_reg   <= '0;
            data_reg  <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            zero_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == IDLE && req) begin
                we_reg   <= we;
                adr_reg  <= adr;
                data_reg <= data_in;
            end
            ack_reg <= enter_resp;
            err_reg <= enter_resp && cur_err;
            // zero_reg masks the RAM output after reset and on error responses
            if (enter_resp) begin
                if (cur_err) begin
                    zero_reg <= 1'b1;
                end else if (!cur_we) begin
                    zero_reg <= 1'b0;
                end
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .wr_en (ram_wr),
        .rd_en (ram_rd),
        .addr  (cur_adr[AW+1:2]),
        .wdata (cur_data),
        .rdata (ram_q)
    );

    assign data_out = zero_reg ? '0 : ram_q;
    assign ack      = ack_reg;
    assign err      = err_reg;

endmodule
